// File: rtl/fma16_stream.sv
// ---------------------------------------------------------------------------
// fma16 / fma16_stream
//
// fma16: combinational binary16 fused multiply-add.
//   result = (+/-)(x * y) (+/-) z, rounded once.
//   mul=0 replaces y with 1.0, add=0 drops z, negp/negz negate product/addend.
//   x, y, z    in  16  binary16 operands
//   mul, add   in  1   enable multiply / addend
//   negp, negz in  1   negate product / addend
//   roundmode  in  2   00 RZ, 01 RNE, 10 RM, 11 RP
//   result     out 16  binary16 result (NaN results are canonical 7E00)
//   flags      out 4   {Invalid, Overflow, Underflow, Inexact}
//
// fma16_stream: valid/ready wrapper around fma16 with one operand stage (S1),
// a DEPTH-entry in-order result queue, sticky exception flags and a counter
// of popped results.
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   x, y, z, roundmode, mul, add, negp, negz, in_tag   request payload
//   out_valid/out_ready           result handshake
//   result, flags, out_tag        head-of-queue result
//   sticky_flags, flags_clear     accumulated flags and their clear
//   op_count                      popped results, modulo 2^16
// ---------------------------------------------------------------------------

module fma16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    // Every finite product and addend fits exactly in an 82-bit fixed-point
    // word whose LSB weighs 2^-48, so the sum is exact and rounded only once.
    localparam int FW = 82;

    function automatic logic [10:0] sig_of(input logic [15:0] v);
        return {(v[14:10] != 5'd0), v[9:0]};
    endfunction

    function automatic logic [6:0] bexp_of(input logic [15:0] v);
        return (v[14:10] == 5'd0) ? 7'd1 : {2'b00, v[14:10]};
    endfunction

    function automatic logic is_nan(input logic [15:0] v);
        return (&v[14:10]) && (|v[9:0]);
    endfunction

    function automatic logic is_snan(input logic [15:0] v);
        return (&v[14:10]) && (|v[9:0]) && !v[9];
    endfunction

    function automatic logic is_inf(input logic [15:0] v);
        return (&v[14:10]) && !(|v[9:0]);
    endfunction

    function automatic logic is_zero(input logic [15:0] v);
        return v[14:0] == 15'd0;
    endfunction

    logic [15:0]   ye;
    logic [15:0]   ze;
    logic          sp;
    logic          sz;
    logic [21:0]   mp;
    logic [FW-1:0] fp;
    logic [FW-1:0] fz;
    logic [FW-1:0] fs;
    logic          ss;
    logic [6:0]    lead;
    logic [6:0]    lsb;
    logic [10:0]   kept;
    logic          rbit;
    logic          sticky;
    logic          inx;
    logic          inc;
    logic [16:0]   enc;
    logic [16:0]   enc_r;
    logic          nan_in;
    logic          snan_in;
    logic          prod_inf;
    logic          prod_zero;
    logic          inf_cancel;
    logic          to_max;

    assign ye = mul ? y : 16'h3C00;
    assign sp = x[15] ^ ye[15] ^ negp;
    // With no addend, a zero of the product's own sign keeps signed-zero products intact.
    assign ze = add ? {z[15] ^ negz, z[14:0]} : {sp, 15'd0};
    assign sz = ze[15];

    assign mp = {11'd0, sig_of(x)} * {11'd0, sig_of(ye)};
    assign fp = {60'd0, mp} << (bexp_of(x) + bexp_of(ye) - 7'd2);
    assign fz = {71'd0, sig_of(ze)} << (bexp_of(ze) + 7'd23);

    // Exact signed-magnitude sum.
    always_comb begin
        fs = '0;
        ss = sp;
        if (sp == sz) begin
            fs = fp + fz;
        end else if (fp >= fz) begin
            fs = fp - fz;
        end else begin
            fs = fz - fp;
            ss = sz;
        end
    end

    // Normalise and round. The kept field starts either 10 bits below the
    // leading one or at the subnormal quantum 2^-24 (bit 24). Packing the
    // exponent as (lsb-24) plus the kept significand lets a rounding carry
    // ripple naturally into the exponent, including up to infinity.
    always_comb begin
        lead = '0;
        for (int i = 0; i < FW; i++) begin
            if (fs[i]) lead = 7'(i);
        end
        lsb    = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
        kept   = 11'(fs >> lsb);
        rbit   = fs[lsb - 7'd1];
        sticky = |(fs & ((82'd1 << (lsb - 7'd1)) - 82'd1));
        inx    = rbit | sticky;
        case (roundmode)
            2'b00:   inc = 1'b0;
            2'b01:   inc = rbit & (sticky | kept[0]);
            2'b10:   inc = inx & ss;
            default: inc = inx & ~ss;
        endcase
        enc   = {lsb - 7'd24, 10'd0} + {6'd0, kept};
        enc_r = enc + {16'd0, inc};
    end

    assign nan_in     = is_nan(x) | is_nan(ye) | is_nan(ze);
    assign snan_in    = is_snan(x) | is_snan(ye) | is_snan(ze);
    assign prod_inf   = is_inf(x) | is_inf(ye);
    assign prod_zero  = is_zero(x) | is_zero(ye);
    assign inf_cancel = prod_inf & is_inf(ze) & (sp != sz);
    assign to_max     = (roundmode == 2'b00) | ((roundmode == 2'b10) & ~ss) |
                        ((roundmode == 2'b11) & ss);

    // Special operands take priority over the rounded finite path.
    // Tininess is detected before rounding.
    always_comb begin
        result = 16'd0;
        flags  = 4'd0;
        if (nan_in || (prod_inf && prod_zero) || inf_cancel) begin
            result   = 16'h7E00;
            flags[3] = snan_in | (prod_inf & prod_zero) | inf_cancel;
        end else if (prod_inf) begin
            result = {sp, 15'h7C00};
        end else if (is_inf(ze)) begin
            result = {sz, 15'h7C00};
        end else if (fs == '0) begin
            result = {(sp == sz) ? sp : (roundmode == 2'b10), 15'd0};
        end else if (enc_r >= 17'h07C00) begin
            result = {ss, to_max ? 15'h7BFF : 15'h7C00};
            flags  = 4'b0101;
        end else begin
            result = {ss, enc_r[14:0]};
            flags  = {2'b00, inx & (lead < 7'd34), inx};
        end
    end
endmodule

module fma16_stream #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     x,
    input  logic [15:0]     y,
    input  logic [15:0]     z,
    input  logic [1:0]      roundmode,
    input  logic            mul,
    input  logic            add,
    input  logic            negp,
    input  logic            negz,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     result,
    output logic [3:0]      flags,
    output logic [TAGW-1:0] out_tag,
    output logic [3:0]      sticky_flags,
    input  logic            flags_clear,
    output logic [15:0]     op_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef struct packed {
        logic [15:0]     x;
        logic [15:0]     y;
        logic [15:0]     z;
        logic [1:0]      roundmode;
        logic            mul;
        logic            add;
        logic            negp;
        logic            negz;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [15:0]     result;
        logic [3:0]      flags;
        logic [TAGW-1:0] tag;
    } entry_t;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    logic          s1_valid_q, s1_valid_d;
    req_t          s1_q, s1_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    sticky_q, sticky_d;
    logic [15:0]   op_count_q, op_count_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [15:0]   fma_result;
    logic [3:0]    fma_flags;

    fma16 u_fma16 (
        .x         (s1_q.x),
        .y         (s1_q.y),
        .z         (s1_q.z),
        .mul       (s1_q.mul),
        .add       (s1_q.add),
        .negp      (s1_q.negp),
        .negz      (s1_q.negz),
        .roundmode (s1_q.roundmode),
        .result    (fma_result),
        .flags     (fma_flags)
    );

    // A full queue still takes the S1 result when the head leaves in the same
    // cycle, which is what keeps in_ready high under sustained traffic.
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid_q && ((count_q < DEPTH_C) || pop);
    assign in_ready  = !s1_valid_q || push;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != '0);

    assign result       = mem_q[head_q].result;
    assign flags        = mem_q[head_q].flags;
    assign out_tag      = mem_q[head_q].tag;
    assign sticky_flags = sticky_q;
    assign op_count     = op_count_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        sticky_d   = (flags_clear ? 4'd0 : sticky_q) | (push ? fma_flags : 4'd0);
        op_count_d = op_count_q + 16'(pop);

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = '{x: x, y: y, z: z, roundmode: roundmode, mul: mul,
                           add: add, negp: negp, negz: negz, tag: in_tag};
        end else if (push) begin
            s1_valid_d = 1'b0;
        end

        if (push) begin
            mem_d[tail_q] = '{result: fma_result, flags: fma_flags, tag: s1_q.tag};
            tail_d        = ptr_next(tail_q);
        end

        if (pop) begin
            head_d = ptr_next(head_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sticky_q   <= '0;
            op_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            op_count_q <= op_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fma16_stream.sv
// ---------------------------------------------------------------------------
// tb_fma16_stream: directed self-checking bench for fma16_stream (DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2
// time units after the edge, well away from the next one.
// ---------------------------------------------------------------------------

module tb_fma16_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  roundmode;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [7:0]  out_tag;
    logic [3:0]  sticky_flags;
    logic        flags_clear;
    logic [15:0] op_count;

    int errors  = 0;
    int checks  = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    fma16_stream #(.DEPTH(2), .TAGW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .z            (z),
        .roundmode    (roundmode),
        .mul          (mul),
        .add          (add),
        .negp         (negp),
        .negz         (negz),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flags        (flags),
        .out_tag      (out_tag),
        .sticky_flags (sticky_flags),
        .flags_clear  (flags_clear),
        .op_count     (op_count)
    );

    // Exact binary16 encoding of a small positive integer (1..2047).
    function automatic logic [15:0] int_to_h(input int n);
        int p;
        int frac;
        p = 0;
        for (int i = 0; i < 11; i++) begin
            if (n[i]) p = i;
        end
        frac = (n << (10 - p)) & 'h3FF;
        return {1'b0, 5'(15 + p), 10'(frac)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az,
                                 input logic [1:0] arm, input logic amul, input logic aadd,
                                 input logic anegp, input logic anegz, input logic [7:0] atag);
        x         = ax;
        y         = ay;
        z         = az;
        roundmode = arm;
        mul       = amul;
        add       = aadd;
        negp      = anegp;
        negz      = anegz;
        in_tag    = atag;
    endtask

    // One request through an empty pipe: accept, one-cycle latency, pop.
    task automatic runOp(input string name, input logic [15:0] ax, input logic [15:0] ay,
                         input logic [15:0] az, input logic [1:0] arm, input logic amul,
                         input logic aadd, input logic anegp, input logic anegz,
                         input logic [7:0] atag, input logic [15:0] eres, input logic [3:0] eflg);
        applyStimulus(ax, ay, az, arm, amul, aadd, anegp, anegz, atag);
        in_valid = 1'b1;
        #1;
        checkOutput({name, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        checkOutput({name, "_not_yet"}, out_valid, 0);
        step();
        checkOutput({name, "_out_valid"}, out_valid, 1);
        checkOutput({name, "_result"}, result, eres);
        checkOutput({name, "_flags"}, flags, eflg);
        checkOutput({name, "_tag"}, out_tag, atag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_ops++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flags_clear = 1'b0;
        applyStimulus(16'h0, 16'h0, 16'h0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0);
        step();
        step();

        // Reset state
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_sticky", sticky_flags, 0);
        checkOutput("rst_op_count", op_count, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", flags, 0);
        checkOutput("rst_tag", out_tag, 0);
        reset = 1'b0;
        step();

        // 2*1+1 = 3
        runOp("single", 16'h4000, 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'h11, 16'h4200, 4'b0000);
        checkOutput("single_op_count", op_count, 1);
        checkOutput("single_sticky", sticky_flags, 0);

        // inf*0 -> invalid
        runOp("invalid", 16'h7C00, 16'h0000, 16'h0000, 2'b01, 1, 1, 0, 0, 8'h22, 16'h7E00, 4'b1000);
        checkOutput("invalid_sticky", sticky_flags, 4'b1000);
        flags_clear = 1'b1;
        step();
        flags_clear = 1'b0;
        checkOutput("clear_sticky", sticky_flags, 0);

        // RZ overflow, with flags_clear in the push cycle
        applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 2'b00, 1, 1, 0, 0, 8'h33);
        in_valid = 1'b1;
        step();
        in_valid    = 1'b0;
        flags_clear = 1'b1;
        step();
        flags_clear = 1'b0;
        checkOutput("ovf_rz_result", result, 16'h7BFF);
        checkOutput("ovf_rz_flags", flags, 4'b0101);
        checkOutput("ovf_rz_sticky", sticky_flags, 4'b0101);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_ops++;
        checkOutput("ovf_rz_op_count", op_count, 3);

        // More datapath corners
        runOp("ovf_rne", 16'h7BFF, 16'h4000, 16'h0000, 2'b01, 1, 1, 0, 0, 8'h34, 16'h7C00, 4'b0101);
        runOp("zero_rne", 16'h3C00, 16'h3C00, 16'hBC00, 2'b01, 1, 1, 0, 0, 8'h35, 16'h0000, 4'b0000);
        runOp("zero_rm", 16'h3C00, 16'h3C00, 16'hBC00, 2'b10, 1, 1, 0, 0, 8'h36, 16'h8000, 4'b0000);
        runOp("mul_only", 16'h4200, 16'h4000, 16'h3C00, 2'b01, 1, 0, 0, 0, 8'h37, 16'h4600, 4'b0000);
        runOp("add_only", 16'h4000, 16'h0000, 16'h3C00, 2'b01, 0, 1, 0, 0, 8'h38, 16'h4200, 4'b0000);
        runOp("negp", 16'h4000, 16'h3C00, 16'h3C00, 2'b01, 1, 1, 1, 0, 8'h39, 16'hBC00, 4'b0000);
        runOp("tie_rne", 16'h3C00, 16'h3C00, 16'h1000, 2'b01, 1, 1, 0, 0, 8'h3A, 16'h3C00, 4'b0001);
        runOp("tie_rp", 16'h3C00, 16'h3C00, 16'h1000, 2'b11, 1, 1, 0, 0, 8'h3B, 16'h3C01, 4'b0001);
        runOp("subnormal", 16'h0401, 16'h3800, 16'h0000, 2'b01, 1, 1, 0, 0, 8'h3C, 16'h0200, 4'b0011);
        checkOutput("acc_sticky", sticky_flags, 4'b0111);

        // Backpressure: three accepted, the fourth stalls
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(int_to_h(k), 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'(k));
            in_valid = 1'b1;
            #1;
            checkOutput("bp_fill_ready", in_ready, 1);
            step();
        end
        applyStimulus(int_to_h(4), 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'd4);
        #1;
        checkOutput("bp_stall_ready", in_ready, 0);
        checkOutput("bp_head_tag", out_tag, 1);
        checkOutput("bp_head_result", result, int_to_h(2));
        step();
        checkOutput("bp_stall_hold", in_ready, 0);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_resume_ready", in_ready, 1);
        step();
        exp_ops++;
        in_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_tag", out_tag, k);
            checkOutput("bp_result", result, int_to_h(k + 1));
            step();
            exp_ops++;
        end
        checkOutput("bp_drained", out_valid, 0);
        out_ready = 1'b0;

        // Full queue plus S1, then 20 cycles of simultaneous push and pop
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(int_to_h(k), 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'(k));
            in_valid = 1'b1;
            #1;
            checkOutput("pp_fill_ready", in_ready, 1);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(int_to_h(i + 4), 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'(i + 4));
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checkOutput("pp_in_ready", in_ready, 1);
            checkOutput("pp_tag", out_tag, i + 1);
            checkOutput("pp_result", result, int_to_h(i + 2));
            step();
            exp_ops++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("pp_still_full", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 21; k <= 23; k++) begin
            checkOutput("pp_drain_tag", out_tag, k);
            checkOutput("pp_drain_result", result, int_to_h(k + 1));
            step();
            exp_ops++;
        end
        checkOutput("pp_drained", out_valid, 0);
        out_ready = 1'b0;
        checkOutput("total_op_count", op_count, exp_ops);
        checkOutput("final_sticky", sticky_flags, 4'b0111);

        // Reset with three requests outstanding and a handshake in flight
        for (int k = 30; k <= 32; k++) begin
            applyStimulus(int_to_h(k), 16'h3C00, 16'h3C00, 2'b01, 1, 1, 0, 0, 8'(k));
            in_valid = 1'b1;
            step();
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_op_count", op_count, 0);
        checkOutput("mid_rst_sticky", sticky_flags, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_rst_no_stale", out_valid, 0);
        end
        checkOutput("post_rst_op_count", op_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
